// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the chess timer countdown core and the
// display-data selector.
//   - FSM state encoding of the countdown core
//   - min:sec field widths and the seconds rollover value
//   - bit offsets of the fields inside the packed 24-bit time word
// Optional feature macro used by this block: INCREMENT_EN (Fischer increment).
package chess_pkg;

    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int SEC_MAX = 59;
    localparam int TIME_W  = 2 * (MIN_W + SEC_W);

    // Packed time word: {a_min, a_sec, b_min, b_sec}
    localparam int B_SEC_LSB = 0;
    localparam int B_MIN_LSB = B_SEC_LSB + SEC_W;
    localparam int A_SEC_LSB = B_MIN_LSB + MIN_W;
    localparam int A_MIN_LSB = A_SEC_LSB + SEC_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_A  = 3'd1,
        RUN_B  = 3'd2,
        PAUSED = 3'd3,
        FLAG   = 3'd4
    } state_t;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } mmss_t;

endpackage

// File: rtl/chess_countdown_mmss_dec.sv
// mmss_dec: one player's min:sec clock register.
//   clk, rst   : clock, async active-high reset (clears to 0:00)
//   load       : load load_min minutes, seconds = 0 (highest priority)
//   dec        : subtract one second (never below 0:00)
//   inc        : add INC_SEC seconds after any same-cycle decrement,
//                saturating at 63:59
//   t          : current value
//   zero / one : value is 0:00 / value is 0:01 (a decrement will expire it)
module mmss_dec
    import chess_pkg::*;
#(
    parameter int INC_SEC = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic             dec,
    input  logic             inc,
    output mmss_t            t,
    output logic             zero,
    output logic             one
);

    mmss_t            d, n;
    logic [SEC_W:0]   s_w;   // one spare bit to see the carry
    logic [MIN_W:0]   m_w;

    always_comb begin
        d = t;
        if (dec) begin
            if (t.sec != '0) begin
                d.sec = t.sec - 1'b1;
            end else if (t.min != '0) begin
                d.sec = SEC_W'(SEC_MAX);
                d.min = t.min - 1'b1;
            end
        end

        // INC_SEC <= 59, so at most one carry into minutes
        s_w = {1'b0, d.sec} + (SEC_W+1)'(INC_SEC);
        m_w = {1'b0, d.min};
        if (s_w > (SEC_W+1)'(SEC_MAX)) begin
            s_w = s_w - (SEC_W+1)'(SEC_MAX + 1);
            m_w = m_w + 1'b1;
        end

        n = d;
        if (inc) begin
            if (m_w[MIN_W]) begin
                n.min = '1;
                n.sec = SEC_W'(SEC_MAX);
            end else begin
                n.min = m_w[MIN_W-1:0];
                n.sec = s_w[SEC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (load) begin
            t.min <= load_min;
            t.sec <= '0;
        end else begin
            t <= n;
        end
    end

    assign zero = (t == '0);
    assign one  = (t.min == '0) && (t.sec == SEC_W'(1));

endmodule

// File: rtl/chess_countdown.sv
// chess_countdown: two-player countdown core of the chess timer.
//   clk, rst            : clock, async active-high reset
//   load, time_in       : load time_in minutes into both clocks (0 s), to IDLE
//   start / pause       : begin or resume / hold counting
//   switch_a / switch_b : player ends move (ignored if not on move, or if both)
//   counted_time        : {a_min, a_sec, b_min, b_sec}
//   active_b            : side on move (remembered while paused)
//   running             : in RUN_A or RUN_B
//   flag_a / flag_b     : sticky expiry flags, cleared by load or rst
// Build option: define INCREMENT_EN to add INC_SEC seconds to the mover's
// clock on every accepted switch (Fischer increment).
module chess_countdown
    import chess_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int INC_SEC = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [MIN_W-1:0]  time_in,
    input  logic              start,
    input  logic              pause,
    input  logic              switch_a,
    input  logic              switch_b,
    output logic [TIME_W-1:0] counted_time,
    output logic              active_b,
    output logic              running,
    output logic              flag_a,
    output logic              flag_b
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    state_t        state, nxt;
    logic [PW-1:0] psc;
    logic          nxt_side, set_fa, set_fb, psc_clr;
    logic          run_st, tick, ok_a, ok_b;
    logic [1:0]    dec, inc, zero, one;
    mmss_t         t [2];      // [0] = player A, [1] = player B

    assign run_st = (state == RUN_A) || (state == RUN_B);
    assign tick   = run_st && (psc == PW'(CLK_HZ - 1));
    assign ok_a   = switch_a & ~switch_b;
    assign ok_b   = switch_b & ~switch_a;
    assign dec[0] = (state == RUN_A) && tick;
    assign dec[1] = (state == RUN_B) && tick;

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_ply
            mmss_dec #(.INC_SEC(INC_SEC)) u_clk (
                .clk      (clk),
                .rst      (rst),
                .load     (load),
                .load_min (time_in),
                .dec      (dec[p]),
                .inc      (inc[p]),
                .t        (t[p]),
                .zero     (zero[p]),
                .one      (one[p])
            );
        end
    endgenerate

    always_comb begin
        nxt      = state;
        nxt_side = active_b;
        set_fa   = 1'b0;
        set_fb   = 1'b0;
        psc_clr  = 1'b0;
        inc      = 2'b00;
        case (state)
            IDLE: if (start) begin
                if (zero[0]) begin
                    nxt    = FLAG;
                    set_fa = 1'b1;
                end else begin
                    nxt      = RUN_A;
                    nxt_side = 1'b0;
                    psc_clr  = 1'b1;
                end
            end
            // expiry beats pause, pause beats switch
            RUN_A: begin
                if (dec[0] && one[0]) begin
                    nxt    = FLAG;
                    set_fa = 1'b1;
                end else if (pause) begin
                    nxt = PAUSED;
                end else if (ok_a) begin
                    nxt      = RUN_B;
                    nxt_side = 1'b1;
`ifdef INCREMENT_EN
                    inc[0]   = 1'b1;
`endif
                end
            end
            RUN_B: begin
                if (dec[1] && one[1]) begin
                    nxt    = FLAG;
                    set_fb = 1'b1;
                end else if (pause) begin
                    nxt = PAUSED;
                end else if (ok_b) begin
                    nxt      = RUN_A;
                    nxt_side = 1'b0;
`ifdef INCREMENT_EN
                    inc[1]   = 1'b1;
`endif
                end
            end
            PAUSED: if (start) begin
                if (zero[active_b]) begin
                    nxt    = FLAG;
                    set_fa = ~active_b;
                    set_fb = active_b;
                end else begin
                    nxt = active_b ? RUN_B : RUN_A;
                end
            end
            default: ;   // FLAG: only load or rst leaves
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active_b <= 1'b0;
            running  <= 1'b0;
            flag_a   <= 1'b0;
            flag_b   <= 1'b0;
            psc      <= '0;
        end else if (load) begin
            state    <= IDLE;
            active_b <= 1'b0;
            running  <= 1'b0;
            flag_a   <= 1'b0;
            flag_b   <= 1'b0;
            psc      <= '0;
        end else begin
            state    <= nxt;
            active_b <= nxt_side;
            running  <= (nxt == RUN_A) || (nxt == RUN_B);
            flag_a   <= flag_a | set_fa;
            flag_b   <= flag_b | set_fb;
            // prescaler phase survives pause and turn switches
            if (psc_clr || tick) psc <= '0;
            else if (run_st)     psc <= psc + 1'b1;
        end
    end

    assign counted_time[A_MIN_LSB +: MIN_W] = t[0].min;
    assign counted_time[A_SEC_LSB +: SEC_W] = t[0].sec;
    assign counted_time[B_MIN_LSB +: MIN_W] = t[1].min;
    assign counted_time[B_SEC_LSB +: SEC_W] = t[1].sec;

endmodule

// File: tb/tb_chess_countdown.sv
// tb_chess_countdown: scoreboard bench for chess_countdown (CLK_HZ = 4).
// Stimulus pushes the reference model's expected outputs with the cycle they
// are due; a negedge monitor pops and compares. Reference keeps each clock as
// total seconds. Define INCREMENT_EN for both DUT and bench to cover the
// increment build.
module tb_chess_countdown;

    localparam int CLK_HZ  = 4;
    localparam int INC_SEC = 5;
    localparam int SAT     = 63 * 60 + 59;

    logic        clk = 1'b0, rst = 1'b1;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic        switch_a = 1'b0, switch_b = 1'b0;
    logic [5:0]  time_in = '0;
    logic [23:0] counted_time;
    logic        active_b, running, flag_a, flag_b;

    always #5 clk = ~clk;

    chess_countdown #(.CLK_HZ(CLK_HZ), .INC_SEC(INC_SEC)) dut (
        .clk(clk), .rst(rst), .load(load), .time_in(time_in),
        .start(start), .pause(pause), .switch_a(switch_a), .switch_b(switch_b),
        .counted_time(counted_time), .active_b(active_b), .running(running),
        .flag_a(flag_a), .flag_b(flag_b)
    );

    typedef struct {
        logic [27:0] v;
        int          due;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   compared = 0, mismatched = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] obs();
        return {counted_time, active_b, running, flag_a, flag_b};
    endfunction

    task automatic chk(input string name, input logic [27:0] got, input logic [27:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (ct|act|run|fa|fb) at cycle %0d", name, got, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_FLAG} mmode_t;
    mmode_t mode = M_IDLE;
    int     ma = 0, mb = 0, mps = 0;
    bit     mside = 0, mfa = 0, mfb = 0;
    string  cur_tag = "reset";

    task automatic model_reset();
        mode = M_IDLE; ma = 0; mb = 0; mps = 0; mside = 0; mfa = 0; mfb = 0;
    endtask

    function automatic logic [27:0] model_word();
        return {6'(ma / 60), 6'(ma % 60), 6'(mb / 60), 6'(mb % 60),
                mside, (mode == M_RUN), mfa, mfb};
    endfunction

    task automatic model_step(input bit ld, input int tin, input bit st,
                              input bit pa, input bit sa, input bit sb);
        bit tick, swok;
        int cur;
        if (ld) begin
            ma = tin * 60; mb = tin * 60;
            mode = M_IDLE; mside = 0; mfa = 0; mfb = 0; mps = 0;
            return;
        end
        tick = (mode == M_RUN) && (mps == CLK_HZ - 1);
        if (mode == M_RUN) mps = tick ? 0 : mps + 1;
        case (mode)
            M_IDLE: if (st) begin
                if (ma == 0) begin mode = M_FLAG; mfa = 1; end
                else begin mode = M_RUN; mside = 0; mps = 0; end
            end
            M_RUN: begin
                cur  = mside ? mb : ma;
                if (tick) cur = cur - 1;
                swok = (sa != sb) && (mside ? sb : sa);
                if (tick && cur == 0) begin
                    mode = M_FLAG;
                    if (mside) mfb = 1; else mfa = 1;
                end else if (pa) begin
                    mode = M_PAUSE;
                end else if (swok) begin
`ifdef INCREMENT_EN
                    cur = (cur + INC_SEC > SAT) ? SAT : cur + INC_SEC;
`endif
                end
                if (mside) mb = cur; else ma = cur;
                if (mode == M_RUN && !pa && swok) mside = !mside;
            end
            M_PAUSE: if (st) begin
                cur = mside ? mb : ma;
                if (cur == 0) begin
                    mode = M_FLAG;
                    if (mside) mfb = 1; else mfa = 1;
                end else mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1: drive, predict, queue, advance one edge.
    task automatic step(input bit ld, input int tin, input bit st,
                        input bit pa, input bit sa, input bit sb);
        exp_t e;
        load = ld; time_in = 6'(tin); start = st; pause = pa;
        switch_a = sa; switch_b = sb;
        model_step(ld, tin, st, pa, sa, sb);
        e.v = model_word(); e.due = cyc + 1; e.tag = cur_tag;
        sbq.push_back(e);
        @(posedge clk); #1;
        load = 0; start = 0; pause = 0; switch_a = 0; switch_b = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk(e.tag, obs(), e.v);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [27:0] w;
        #2 chk("reset_state", obs(), 28'h0);
        #20; @(negedge clk) rst = 0;
        model_reset();
        @(posedge clk); #1;

        cur_tag = "load2";
        step(1, 2, 0, 0, 0, 0);
        chk("load2_direct", obs(), {24'h080080, 4'b0000});
        idle(2);

        cur_tag = "first_tick";
        step(1, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); idle(4);
        chk("first_tick_direct", obs(), {6'd0, 6'd59, 6'd1, 6'd0, 4'b0100});

        cur_tag = "switch_ticks";
        step(1, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); idle(4);
        step(0, 0, 0, 0, 1, 0); idle(7);
`ifdef INCREMENT_EN
        w = {6'd1, 6'd4, 6'd0, 6'd58, 4'b1100};
`else
        w = {6'd0, 6'd59, 6'd0, 6'd58, 4'b1100};
`endif
        chk("switch_ticks_direct", obs(), w);

        cur_tag = "start_zero";
        step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
        chk("start_zero_direct", obs(), {24'h0, 4'b0010});
        idle(2);

        cur_tag = "pause_resume";
        step(1, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); idle(2);
        step(0, 0, 0, 1, 0, 0); idle(20);
        chk("pause_hold_direct", obs(), {6'd1, 6'd0, 6'd1, 6'd0, 4'b0000});
        step(0, 0, 1, 0, 0, 0); idle(6);

        cur_tag = "both_switch";
        step(1, 1, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); idle(1);
        step(0, 0, 0, 0, 1, 1);
        chk("both_switch_direct", {27'h0, active_b}, 28'h0);
        cur_tag = "pause_vs_switch";
        step(0, 0, 0, 1, 1, 0); step(0, 0, 1, 0, 0, 0);
        cur_tag = "into_run_b";
        step(0, 0, 0, 0, 1, 0); idle(3);

        // async reset in RUN_B, away from any edge
        @(negedge clk); #1;
        rst = 1; #1;
        chk("async_rst", obs(), 28'h0);
        @(posedge clk); @(negedge clk) rst = 0;
        model_reset();
        @(posedge clk); #1;

        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 2),
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
        end

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            compared++; mismatched++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
